// File: rtl/counter_arbiter_pkg.sv
// Shared definitions for the counter-family blocks.
// State encodings and default widths used by counter_arbiter and siblings.
package counter_arbiter_pkg;

  localparam int CNT_W_DEF = 6;
  localparam int N_REQ_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/counter_arbiter_cnt_core.sv
// Plain synchronous up-counter; clr wins over en.
// The arbiter is its only master.
module cnt_core #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin owner of one shared interval counter.
// Grants, runs for len cycles, then pulses done to the owner.
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] len,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [CNT_W-1:0]       count
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;

  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_val;
  logic [IDX_W-1:0] pick;
  logic [CNT_W-1:0] pick_len;

  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [N_REQ-1:0] r,
    input logic [IDX_W-1:0] p
  );
    logic found;
    int   idx;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(p) + i) % N_REQ;
      if (!found && r[idx]) begin
        rr_pick = IDX_W'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [IDX_W-1:0] nxt_idx(
    input logic [IDX_W-1:0] i
  );
    if (i == IDX_W'(N_REQ - 1)) begin
      nxt_idx = '0;
    end else begin
      nxt_idx = i + IDX_W'(1);
    end
  endfunction

  function automatic logic [N_REQ-1:0] onehot(
    input logic [IDX_W-1:0] i
  );
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  always_comb begin
    pick     = rr_pick(req, rr_ptr_q);
    pick_len = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == IDX_W'(i)) begin
        pick_len = len[i*CNT_W +: CNT_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    len_d    = len_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          owner_d = pick;
          len_d   = pick_len;
          cnt_clr = 1'b1;
          state_d = (pick_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort beats terminal count.
        if (!req[owner_q]) begin
          state_d  = ST_IDLE;
          cnt_clr  = 1'b1;
          rr_ptr_d = nxt_idx(owner_q);
        end else begin
          cnt_en = 1'b1;
          if (cnt_val == len_q - CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        cnt_clr  = 1'b1;
        rr_ptr_d = nxt_idx(owner_q);
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // Outputs are flopped from the next-state view.
  always_comb begin
    gnt_d  = '0;
    done_d = '0;
    busy_d = 1'b0;
    if (state_d != ST_IDLE) begin
      gnt_d  = onehot(owner_d);
      busy_d = 1'b1;
    end
    if (state_d == ST_DONE) begin
      done_d = onehot(owner_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      len_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      len_q    <= len_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  cnt_core #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .count(cnt_val)
  );

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = cnt_val;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_counter_arbiter;

  localparam int N = 4;
  localparam int W = 6;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] len;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   count;

  int n_tests;
  int n_fail;

  // Model: owner (-1 idle), cycles since grant, granted length, pointer.
  int m_owner;
  int m_t;
  int m_len;
  int m_ptr;

  counter_arbiter #(
    .N_REQ(N),
    .CNT_W(W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len  (len),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_len(input int i, input int v);
    len[i*W +: W] = W'(v);
  endtask

  function automatic int slice_len(input int i);
    logic [W-1:0] s;
    s = len[i*W +: W];
    return int'(s);
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_t     = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_len   = slice_len(c);
          m_t     = 0;
        end
      end
    end else if (m_t == m_len) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else if (!req[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
      m_t++;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] eg;
    logic [N-1:0] ed;
    int           ec;
    eg = '0;
    ed = '0;
    ec = 0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ec          = m_t;
      if (m_t == m_len) ed[m_owner] = 1'b1;
    end
    check("gnt", 32'(gnt), 32'(eg));
    check("done", 32'(done), 32'(ed));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("count", 32'(count), 32'(ec));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int ngr;
    int order[$];
    logic [N-1:0] prev_g;
    int gcyc;
    int maxc;
    int bound;

    n_tests = 0;
    n_fail  = 0;
    m_owner = -1;
    m_t     = 0;
    m_len   = 0;
    m_ptr   = 0;
    rst     = 1'b1;
    req     = '0;
    len     = '0;

    // 1: reset, then a len=5 interval on requester 0
    step();
    step();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    rst = 1'b0;
    req = 4'b0001;
    set_len(0, 5);
    step();
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_cnt0", 32'(count), 32'h0);
    repeat (4) step();
    check("t1_cnt4", 32'(count), 32'h4);
    step();
    check("t1_done", 32'(done), 32'h1);
    check("t1_cnt5", 32'(count), 32'h5);
    req = '0;
    step();
    check("t1_gnt_off", 32'(gnt), 32'h0);

    // 2: zero-length interval
    req = 4'b0100;
    set_len(2, 0);
    step();
    check("t2_gnt", 32'(gnt), 32'h4);
    check("t2_done", 32'(done), 32'h4);
    req = '0;
    step();
    check("t2_idle", 32'(gnt), 32'h0);

    // 3: all requesting, round-robin order
    do_reset();
    for (int i = 0; i < N; i++) set_len(i, 2);
    req    = 4'b1111;
    prev_g = '0;
    bound  = 0;
    while (order.size() < 5 && bound < 60) begin
      step();
      bound++;
      if (prev_g == '0 && gnt != '0) begin
        for (int i = 0; i < N; i++)
          if (gnt[i]) order.push_back(i);
      end
      check("t3_onehot", 32'($countones(gnt) <= 1), 32'h1);
      prev_g = gnt;
    end
    check("t3_ngrants", 32'(order.size()), 32'd5);
    if (order.size() == 5) begin
      check("t3_o0", 32'(order[0]), 32'd0);
      check("t3_o1", 32'(order[1]), 32'd1);
      check("t3_o2", 32'(order[2]), 32'd2);
      check("t3_o3", 32'(order[3]), 32'd3);
      check("t3_o4", 32'(order[4]), 32'd0);
    end
    req = '0;
    repeat (3) step();

    // 4: abort at count 4, then pointer skips past the aborted owner
    req = 4'b0010;
    set_len(1, 10);
    bound = 0;
    step();
    while (!(m_owner == 1 && m_t == 4) && bound < 30) begin
      step();
      bound++;
    end
    check("t4_reach", 32'(count), 32'd4);
    req = '0;
    step();
    check("t4_gnt0", 32'(gnt), 32'h0);
    check("t4_cnt0", 32'(count), 32'h0);
    check("t4_nodone", 32'(done), 32'h0);
    req = 4'b0101;
    step();
    check("t4_rr", 32'(gnt), 32'h4);
    req = '0;
    repeat (4) step();

    // 5: reset mid-interval
    req = 4'b0001;
    set_len(0, 8);
    bound = 0;
    step();
    while (!(m_owner == 0 && m_t == 3) && bound < 30) begin
      step();
      bound++;
    end
    check("t5_reach", 32'(count), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_gnt", 32'(gnt), 32'h0);
    check("t5_done", 32'(done), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_cnt", 32'(count), 32'h0);
    req = 4'b1111;
    step();
    check("t5_ptr0", 32'(gnt), 32'h1);
    req = '0;
    repeat (3) step();

    // 6: maximum length, no wrap
    do_reset();
    req = 4'b1000;
    set_len(3, 63);
    gcyc  = 0;
    maxc  = 0;
    bound = 0;
    do begin
      step();
      bound++;
      if (gnt != '0) gcyc++;
      if (int'(count) > maxc) maxc = int'(count);
    end while (done == '0 && bound < 100);
    req = '0;
    step();
    check("t6_gcyc", 32'(gcyc), 32'd64);
    check("t6_max", 32'(maxc), 32'd63);

    // Random traffic
    do_reset();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(3) == 0) req = N'($urandom);
      if ($urandom_range(7) == 0) begin
        for (int i = 0; i < N; i++)
          set_len(i, $urandom_range(9));
      end
      if ($urandom_range(15) == 0) set_len(0, $urandom_range(63));
      rst = ($urandom_range(99) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
